// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage pipelined extended-Hamming SECDED decoder with a valid/ready stream and saturating SEC/DED counters.
// Optional feature macro SECDED_INJECT_EN adds inj_mask, which is XORed into in_code at capture.
module hamming_secded_stream_decoder #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16,
  localparam int PAR_W = (DATA_W <= 1)   ? 2 :
                         (DATA_W <= 4)   ? 3 :
                         (DATA_W <= 11)  ? 4 :
                         (DATA_W <= 26)  ? 5 :
                         (DATA_W <= 57)  ? 6 :
                         (DATA_W <= 120) ? 7 : 8,
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
`ifdef SECDED_INJECT_EN
  input  logic [CODE_W-1:0] inj_mask,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [PAR_W:0]    out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Producers hold valid and payload stable until accepted; ready may depend
  // combinationally on downstream ready but valid never depends on ready.

  localparam logic [PAR_W:0] CODE_LIM = (PAR_W+1)'(CODE_W);

  // Hamming position of the k-th data bit: k-th non-power-of-two position.
  function automatic int data_pos(input int k);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int p = 3; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) pos = p;
        n++;
      end
    end
    return pos;
  endfunction

  logic              r_s1_valid;
  logic [CODE_W-1:0] r_s1_code;
  logic [PAR_W-1:0]  r_s1_syn;
  logic              r_s1_f;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sec;
  logic              r_out_ded;
  logic [PAR_W:0]    r_out_syn;
  logic [CNT_W-1:0]  r_sec_cnt;
  logic [CNT_W-1:0]  r_ded_cnt;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [CODE_W-1:0] w_cap_code;
  logic [PAR_W-1:0]  w_syn;
  logic              w_par_f;
  logic              w_syn_nz;
  logic              w_in_range;
  logic              w_flip;
  logic              w_sec;
  logic              w_ded;
  logic [CODE_W-1:0] w_fix_code;
  logic [DATA_W-1:0] w_data;

  assign w_s2_adv   = !r_out_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_in_fire  = in_valid && w_s1_adv;
  assign w_out_fire = r_out_valid && out_ready;

  // Gated by rst so no handshake can be observed during a reset cycle.
  assign in_ready  = w_s1_adv && !rst;
  assign out_valid = r_out_valid && !rst;

`ifdef SECDED_INJECT_EN
  assign w_cap_code = in_code ^ inj_mask;
`else
  assign w_cap_code = in_code;
`endif

  always_comb begin
    w_syn = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (w_cap_code[i-1]) w_syn = w_syn ^ PAR_W'(i);
    end
  end

  assign w_par_f = ^w_cap_code;

  // Syndromes past the last real position only arise in shortened codes.
  assign w_syn_nz   = |r_s1_syn;
  assign w_in_range = {1'b0, r_s1_syn} < CODE_LIM;
  assign w_flip     = r_s1_f && w_syn_nz && w_in_range;
  assign w_sec      = r_s1_f && (!w_syn_nz || w_in_range);
  assign w_ded      = w_syn_nz && (!r_s1_f || !w_in_range);

  for (genvar gp = 1; gp < CODE_W; gp++) begin : g_fix
    assign w_fix_code[gp-1] = r_s1_code[gp-1] ^ (w_flip && (r_s1_syn == PAR_W'(gp)));
  end
  assign w_fix_code[CODE_W-1] = r_s1_code[CODE_W-1];

  for (genvar gk = 0; gk < DATA_W; gk++) begin : g_data
    assign w_data[gk] = w_fix_code[data_pos(gk) - 1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_code   <= '0;
      r_s1_syn    <= '0;
      r_s1_f      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sec   <= 1'b0;
      r_out_ded   <= 1'b0;
      r_out_syn   <= '0;
      r_sec_cnt   <= '0;
      r_ded_cnt   <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (w_in_fire) begin
          r_s1_code <= w_cap_code;
          r_s1_syn  <= w_syn;
          r_s1_f    <= w_par_f;
        end
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_data;
          r_out_sec  <= w_sec;
          r_out_ded  <= w_ded;
          r_out_syn  <= {r_s1_f, r_s1_syn};
        end
      end
      // Clear takes priority over a coincident increment.
      if (cnt_clr) begin
        r_sec_cnt <= '0;
      end else if (w_out_fire && r_out_sec && (r_sec_cnt != '1)) begin
        r_sec_cnt <= r_sec_cnt + CNT_W'(1);
      end
      if (cnt_clr) begin
        r_ded_cnt <= '0;
      end else if (w_out_fire && r_out_ded && (r_ded_cnt != '1)) begin
        r_ded_cnt <= r_ded_cnt + CNT_W'(1);
      end
    end
  end

  assign out_data     = r_out_data;
  assign out_sec      = r_out_sec;
  assign out_ded      = r_out_ded;
  assign out_syndrome = r_out_syn;
  assign sec_count    = r_sec_cnt;
  assign ded_count    = r_ded_cnt;

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Self-checking bench for hamming_secded_stream_decoder: directed vector table, handshake corner
// sequences, random traffic against a brute-force SECDED model, and a DATA_W=8/CNT_W=2 instance.
module tb_hamming_secded_stream_decoder;

  typedef struct {
    logic [7:0] code;
    logic [3:0] data;
    logic       sec;
    logic       ded;
    logic [3:0] syn;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_code;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        out_sec;
  logic        out_ded;
  logic [3:0]  out_syndrome;
  logic        cnt_clr;
  logic [15:0] sec_count;
  logic [15:0] ded_count;

  logic        in8_valid;
  logic        in8_ready;
  logic [12:0] in8_code;
  logic        out8_valid;
  logic        out8_ready;
  logic [7:0]  out8_data;
  logic        out8_sec;
  logic        out8_ded;
  logic [4:0]  out8_syndrome;
  logic        cnt8_clr;
  logic [1:0]  sec8_count;
  logic [1:0]  ded8_count;

`ifdef SECDED_INJECT_EN
  logic [7:0]  inj_mask_v;
  logic [12:0] inj8_mask_v;
`endif

  logic [9:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_sec    = 0;
  int          m_ded    = 0;
  bit          bp_en    = 1'b0;

  vec_t        vecs[19];
  logic [7:0]  clean_codes[16] = '{8'h00, 8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4,
                                   8'h4B, 8'hCC, 8'hD2, 8'h55, 8'hE1, 8'h66, 8'h78, 8'hFF};
  logic [7:0]  bp_codes[6];

  always #5 clk = ~clk;

  hamming_secded_stream_decoder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
`ifdef SECDED_INJECT_EN
    .inj_mask(inj_mask_v),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sec(out_sec),
    .out_ded(out_ded), .out_syndrome(out_syndrome), .cnt_clr(cnt_clr),
    .sec_count(sec_count), .ded_count(ded_count)
  );

  hamming_secded_stream_decoder #(.DATA_W(8), .CNT_W(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in8_valid), .in_ready(in8_ready), .in_code(in8_code),
`ifdef SECDED_INJECT_EN
    .inj_mask(inj8_mask_v),
`endif
    .out_valid(out8_valid), .out_ready(out8_ready), .out_data(out8_data), .out_sec(out8_sec),
    .out_ded(out8_ded), .out_syndrome(out8_syndrome), .cnt_clr(cnt8_clr),
    .sec_count(sec8_count), .ded_count(ded8_count)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: encode from the parity-coverage rule, decode by searching for a
  // codeword at distance 0 or 1.
  function automatic logic [7:0] m_encode(input logic [3:0] d);
    logic [7:0] c;
    logic       par;
    int         dp[4] = '{3, 5, 6, 7};
    c = '0;
    for (int k = 0; k < 4; k++) c[dp[k]-1] = d[k];
    for (int p = 1; p < 8; p = p * 2) begin
      par = 1'b0;
      for (int q = 1; q < 8; q++) if (((q & p) != 0) && (q != p)) par = par ^ c[q-1];
      c[p-1] = par;
    end
    c[7] = ^c[6:0];
    return c;
  endfunction

  function automatic logic [3:0] m_extract(input logic [7:0] c);
    return {c[6], c[5], c[4], c[2]};
  endfunction

  function automatic logic [9:0] m_decode(input logic [7:0] c);
    logic [2:0] s;
    logic [3:0] d;
    logic [7:0] t;
    logic       sec;
    logic       ded;
    s = '0;
    for (int i = 1; i < 8; i++) if (c[i-1]) s = s ^ 3'(i);
    d   = m_extract(c);
    sec = 1'b0;
    ded = 1'b0;
    if (m_encode(m_extract(c)) != c) begin
      ded = 1'b1;
      for (int b = 0; b < 8; b++) begin
        t = c ^ (8'h01 << b);
        if (m_encode(m_extract(t)) == t) begin
          sec = 1'b1;
          ded = 1'b0;
          d   = m_extract(t);
        end
      end
    end
    return {d, sec, ded, ^c, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [7:0] code, input logic [9:0] exp);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_code  = code;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        got = 1'b1;
      end
      tick();
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for code %0h", code);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", exp_q.size(), 0);
    tick();
  endtask

  task automatic send8(input logic [12:0] code, input logic [7:0] ed, input logic es,
                       input logic ee, input logic [4:0] esyn, input string name);
    in8_valid = 1'b1;
    in8_code  = code;
    @(negedge clk);
    check({name, "_in_ready"}, in8_ready, 1);
    tick();
    in8_valid = 1'b0;
    tick();
    @(negedge clk);
    check({name, "_valid"}, out8_valid, 1);
    check({name, "_data"}, out8_data, ed);
    check({name, "_sec"}, out8_sec, es);
    check({name, "_ded"}, out8_ded, ee);
    check({name, "_syn"}, out8_syndrome, esyn);
    tick();
  endtask

  // Output monitor: scoreboard compare on each output handshake, hold check while stalled.
  initial begin
    logic [9:0] act;
    logic [9:0] prev_act;
    logic [9:0] e;
    bit         prev_stall;
    prev_stall = 1'b0;
    prev_act   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        act = {out_data, out_sec, out_ded, out_syndrome};
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_payload", act, prev_act);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0h with no word pending", act);
          end else begin
            e = exp_q.pop_front();
            check("out_word", act, e);
            if (e[5]) m_sec++;
            if (e[4]) m_ded++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_act   = act;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         acc;
    int         idx;
    bit         hs;
    bit         seen;
    logic [3:0] d;
    logic [7:0] c;
    int         k;
    int         b0;
    int         b1;

    for (int i = 0; i < 16; i++) vecs[i] = '{clean_codes[i], 4'(i), 1'b0, 1'b0, 4'h0};
    vecs[16] = '{8'h8F, 4'h1, 1'b1, 1'b0, 4'b1100};
    vecs[17] = '{8'h80, 4'h0, 1'b1, 1'b0, 4'b1000};
    vecs[18] = '{8'hEB, 4'hC, 1'b0, 1'b1, 4'b0110};

    rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    in8_valid = 1'b0; in8_code = '0; out8_ready = 1'b1; cnt8_clr = 1'b0;
`ifdef SECDED_INJECT_EN
    inj_mask_v = '0; inj8_mask_v = '0;
`endif

    // Power-on reset
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sec", out_sec, 0);
    check("rst_out_ded", out_ded, 0);
    check("rst_out_syn", out_syndrome, 0);
    check("rst_sec_count", sec_count, 0);
    check("rst_ded_count", ded_count, 0);
    check("rst_in_ready", in_ready, 1);
    tick();

    // Directed table: 16 clean words back-to-back, then single and double flips
    for (int i = 0; i < 19; i++)
      send(vecs[i].code, {vecs[i].data, vecs[i].sec, vecs[i].ded, vecs[i].syn});
    drain();

    // Two-cycle latency
    send(8'h87, {4'h1, 1'b0, 1'b0, 4'h0});
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
    tick();
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    tick();
    drain();

    // Backpressure: in_valid held, out_ready low for 5 cycles
    for (int i = 0; i < 6; i++) bp_codes[i] = m_encode(4'(i + 5)) ^ ((i == 2) ? 8'h10 : 8'h00);
    out_ready = 1'b0;
    acc = 0;
    idx = 0;
    in_valid = 1'b1;
    in_code = bp_codes[0];
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      hs = in_ready;
      if (hs) begin
        exp_q.push_back(m_decode(bp_codes[idx]));
        acc++;
      end
      tick();
      if (hs) begin
        idx++;
        in_code = bp_codes[idx];
      end
    end
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_accepted", acc, 2);
    tick();
    out_ready = 1'b1;
    for (int i = idx; i < 6; i++) send(bp_codes[i], m_decode(bp_codes[i]));
    drain();

    // Counters: 3 SEC + 2 DED, then clear coincident with a SEC handshake
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_sec_count", sec_count, 0);
    check("clr_ded_count", ded_count, 0);
    tick();
    send(8'h8F, m_decode(8'h8F));
    send(8'hEB, m_decode(8'hEB));
    send(8'h80, m_decode(8'h80));
    send(8'h03, m_decode(8'h03));
    send(8'h86, m_decode(8'h86));
    drain();
    @(negedge clk);
    check("cnt_sec_3", sec_count, 3);
    check("cnt_ded_2", ded_count, 2);
    tick();
    out_ready = 1'b0;
    send(8'h8F, m_decode(8'h8F));
    in_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else tick();
    end
    check("clr_wait_out_valid", seen, 1);
    tick();
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_wins_sec", sec_count, 0);
    check("clr_wins_ded", ded_count, 0);
    tick();
    drain();

`ifdef SECDED_INJECT_EN
    inj_mask_v = 8'h08;
    send(8'h87, {4'h1, 1'b1, 1'b0, 4'b1100});
    inj_mask_v = 8'h80;
    send(8'h00, {4'h0, 1'b1, 1'b0, 4'b1000});
    inj_mask_v = 8'h14;
    send(8'hFF, {4'hC, 1'b0, 1'b1, 4'b0110});
    inj_mask_v = 8'h00;
    drain();
`endif

    // Random traffic with random backpressure against the model
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    m_sec = 0;
    m_ded = 0;
    bp_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      d = 4'($urandom_range(0, 15));
      c = m_encode(d);
      k = $urandom_range(0, 3);
      b0 = $urandom_range(0, 7);
      b1 = (b0 + $urandom_range(1, 7)) % 8;
      if (k == 1) c = c ^ (8'h01 << b0);
      if (k == 2) c = c ^ (8'h01 << b0) ^ (8'h01 << b1);
      if (k == 3) c = 8'($urandom_range(0, 255));
      send(c, m_decode(c));
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    drain();
    bp_en = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rand_sec_count", sec_count, m_sec);
    check("rand_ded_count", ded_count, m_ded);
    tick();

    // Reset mid-stream discards in-flight words
    send(8'h8F, m_decode(8'h8F));
    send(8'hEB, m_decode(8'hEB));
    send(8'h99, m_decode(8'h99));
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    tick();
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_sec", out_sec, 0);
    check("mid_rst_out_ded", out_ded, 0);
    check("mid_rst_out_syn", out_syndrome, 0);
    check("mid_rst_sec_count", sec_count, 0);
    check("mid_rst_ded_count", ded_count, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    for (int t = 0; t < 5; t++) begin
      tick();
      @(negedge clk);
      check("post_rst_no_stale", out_valid, 0);
    end
    tick();

    // DATA_W=8, CNT_W=2 instance: shortened-code DED, correction, saturation
    send8(13'h0089, 8'h00, 1'b0, 1'b1, 5'b11101, "w8_syn13");
    send8(13'h1003, 8'h01, 1'b1, 1'b0, 5'b10011, "w8_fix_d0");
    for (int i = 0; i < 4; i++) send8(13'h1000, 8'h00, 1'b1, 1'b0, 5'b10000, "w8_par");
    @(negedge clk);
    check("w8_sec_saturate", sec8_count, 3);
    check("w8_ded_count", ded8_count, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
